// File: rtl/adder_arbiter.sv
// adder_arbiter: time-shares one external WIDTH-bit add/subtract unit between
// the PC incrementer (requester 0) and the branch-target calculator
// (requester 1). One operation is in flight at a time. Each operation takes
// three states: accept (IDLE), drive the adder (ISSUE), and hold the result
// until it is consumed (RESP).
module adder_arbiter #(
    parameter int WIDTH      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [1:0]       req_sub,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cout,
    input  logic             add_ov,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_ov
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   winner;

    // Pick the winning requester and raise its ready while the block is idle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner    = req_valid[1];
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    // Operation sequencer: latch the winner's operands, capture the adder
    // result one edge later, then hold the response until it is consumed.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register in
        // this block samples the values from before the edge.
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            add_x      <= '0;
            add_y      <= '0;
            add_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
            rsp_ov     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        add_x      <= winner ? req1_x : req0_x;
                        add_y      <= winner ? req1_y : req0_y;
                        add_cin    <= req_sub[winner];
                        rsp_id     <= winner;
                        last_grant <= winner;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data  <= add_out;
                    rsp_cout  <= add_cout;
                    rsp_ov    <= add_ov;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Time-shares one 16-bit combinational add/subtract unit between two requesters: requester 0 is the PC incrementer, requester 1 is the branch-target calculator.
- Grants one request at a time using round-robin or fixed priority.
- Registers the operands, drives the shared adder, captures the sum, carry-out and overflow, and returns the result with a valid/ready handshake.
- Sits between the PC/branch logic and the shared adder instance in the fetch stage.

Parameters:
- WIDTH, 16, operand and result width; must match the shared adder.
- FIXED_PRIO, 0, 0 selects round-robin; 1 makes requester 0 always win.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation is accepted this cycle (one-hot or zero).
- req0_x, req0_y  input  WIDTH each  requester 0 operands.
- req1_x, req1_y  input  WIDTH each  requester 1 operands.
- req_sub  input  2  bit i: requester i asks for x-y instead of x+y.
- add_x, add_y  output  WIDTH each  operands driven to the shared adder.
- add_cin  output  1  shared adder Cin; 1 = subtract (adder inverts y and adds 1).
- add_out  input  WIDTH  shared adder sum.
- add_cout  input  1  shared adder carry-out.
- add_ov  input  1  shared adder overflow.
- rsp_valid  output  1  response is available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  which requester the response belongs to.
- rsp_data  output  WIDTH  result.
- rsp_cout  output  1  captured carry-out.
- rsp_ov  output  1  captured overflow.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs are 0: req_ready, add_x, add_y, add_cin, rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_ov.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid bit is set, the arbiter picks a winner w and asserts req_ready[w] combinationally in that cycle.
  - At the clock edge it latches the winner's x, y and sub into add_x, add_y and add_cin, latches rsp_id = w, and moves to ISSUE.
  - If no request is valid, it stays in IDLE and req_ready = 0.
- Arbitration:
  - One requester valid: that requester wins.
  - Both valid, FIXED_PRIO = 0: winner = ~last_grant, and last_grant updates on each grant.
  - Both valid, FIXED_PRIO = 1: requester 0 always wins; last_grant is unused.
- ISSUE:
  - add_x, add_y and add_cin are stable from registers.
  - At the edge, add_out, add_cout and add_ov are captured into rsp_data, rsp_cout and rsp_ov.
  - rsp_valid is set to 1 and the state moves to RESP.
- RESP:
  - rsp_* outputs hold stable while rsp_valid = 1 and rsp_ready = 0.
  - When rsp_valid and rsp_ready are both 1 at an edge: rsp_valid goes to 0 and the state returns to IDLE.
  - No new request is accepted in RESP; req_ready = 0.
- Latency and throughput:
  - Accept at edge N gives rsp_valid = 1 after edge N+1.
  - With rsp_ready held at 1, the maximum rate is one operation per 3 cycles.
- add_x, add_y and add_cin keep their last values outside ISSUE and are not cleared on completion.
- Arithmetic is modulo 2^WIDTH. The block performs no arithmetic itself; cout and ov pass through unmodified.
- A request that loses arbitration keeps req_valid high. Its operands must stay stable until req_ready is seen; the block never drops or reorders a granted operation.
- req_ready is never asserted for a requester whose req_valid is 0.
- Reset asserted mid-operation (ISSUE or RESP): the in-flight operation is discarded with no response, and the next cycle is IDLE with reset values.
- req_valid changes while the block is busy are ignored until IDLE.

Test Plan:
- Add: reset, then requester 0 presents x=0x0040, y=0x0004, sub=0 -> req_ready=2'b01 in the first IDLE cycle; two edges later rsp_valid=1, rsp_id=0, rsp_data=0x0044, cout=0, ov=0.
- Subtract: requester 1 presents x=0x0005, y=0x0007, sub=1 -> add_cin=1; rsp_data=0xFFFE, cout=0, ov=0, rsp_id=1.
- Flags:
  - 0x7FFF+0x0001 -> data 0x8000, cout=0, ov=1.
  - 0xFFFF+0x0001 -> data 0x0000, cout=1, ov=0.
- Round-robin: both requesters valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1 with ready pulses 3 cycles apart. With FIXED_PRIO=1 -> every grant goes to 0.
- Backpressure: rsp_ready=0 for 5 cycles while requester 1 is valid -> rsp_* outputs stable and req_ready=0 throughout. After rsp_ready=1 -> the next IDLE cycle grants requester 1.
- Reset mid-op: reset asserted in ISSUE -> rsp_valid stays 0 and all outputs are 0 the following cycle. Requester 0 then requests again -> it is granted first (last_grant=1).
